// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the round-robin lock arbiter.
//   arb_state_e      : arbiter state (ARB_IDLE = no owner, ARB_BUSY = owner held)
//   onehot_from_idx  : index -> one-hot vector (32 bits wide; callers truncate,
//                      so the arbiter supports up to 32 requesters)
// -----------------------------------------------------------------------------
package arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   function automatic logic [31:0] onehot_from_idx(input logic [31:0] idx);
      return 32'd1 << idx;
   endfunction

endpackage : arb_pkg

// File: rtl/pri_enc.sv
// -----------------------------------------------------------------------------
// pri_enc
// MSB-first priority encoder: reports the index of the highest active bit.
// Parameters:
//   IN  : input vector width (>= 2)
//   ACT : 1 = bits are active high, 0 = bits are active low
// Ports:
//   in_i    [IN-1:0] : candidate vector
//   idx_o   [IW-1:0] : index of the highest active bit (0 when none)
//   valid_o          : at least one bit is active
// -----------------------------------------------------------------------------
module pri_enc #(
   parameter int  IN  = 8,
   parameter bit  ACT = 1'b1,
   localparam int IW  = (IN > 1) ? $clog2(IN) : 1
) (
   input  logic [IN-1:0] in_i,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   logic [IN-1:0] vec;

   assign vec     = ACT ? in_i : ~in_i;
   assign valid_o = |vec;

   // Ascending scan: the last hit, i.e. the highest set bit, wins.
   always_comb begin
      idx_o = '0;
      for (int i = 0; i < IN; i++) begin
         if (vec[i]) idx_o = IW'(i);
      end
   end

endmodule : pri_enc

// File: rtl/rr_lock_arbiter.sv
// -----------------------------------------------------------------------------
// rr_lock_arbiter
// Registered round-robin arbiter with grant locking for one single-owner
// resource. The owner keeps its grant for as long as it holds req; when it
// drops req the grant moves in the same edge to the next requester in
// descending round-robin order (starting just below the previous owner).
//
// Optional feature macro: RR_ARB_BURST_LIMIT_EN
//   When defined, an owner that has held the grant for MAX_BURST cycles while
//   another requester waits is forced off, and preempt pulses for one cycle.
//   When undefined, grants are held indefinitely and preempt is tied to 0.
//
// Parameters:
//   REQ       : number of requesters (2..32)
//   MAX_BURST : grant-hold limit in cycles (>= 1, burst-limit build only)
//   IDX       : index width, $clog2(REQ) (not overridable)
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   req          [REQ-1:0] : request/hold, one bit per requester
//   grant        [REQ-1:0] : one-hot grant, registered
//   grant_valid            : |grant, registered
//   grant_idx    [IDX-1:0] : owner index (0 when idle), registered
//   preempt                : one-cycle pulse on a forced hand-off
//   dbg_state_o            : current arbiter state, for observation
//
// Handshake: a requester raises req and keeps it high until it is done with
// the resource; it owns the resource exactly in the cycles where its grant
// bit is 1, and it releases by dropping req (grant moves one edge later).
// -----------------------------------------------------------------------------
module rr_lock_arbiter
   import arb_pkg::*;
#(
   parameter int  REQ       = 8,
   parameter int  MAX_BURST = 16,
   localparam int IDX       = $clog2(REQ)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REQ-1:0]   req,
   output logic [REQ-1:0]   grant,
   output logic             grant_valid,
   output logic [IDX-1:0]   grant_idx,
   output logic             preempt,
   output arb_state_e       dbg_state_o
);

   // ---------------------------------------------------------------- state
   arb_state_e     state_q, state_d;
   logic [REQ-1:0] grant_q, grant_d;
   logic [IDX-1:0] idx_q,   idx_d;
   logic [IDX-1:0] last_q,  last_d;
   logic           valid_q, valid_d;

   // ---------------------------------------------------------- arbitration
   logic [IDX-1:0] arb_last;
   logic [REQ-1:0] rr_mask;
   logic [REQ-1:0] req_masked;
   logic [IDX-1:0] m_idx, f_idx, win_idx;
   logic           m_valid, f_valid, win_valid;
   logic [REQ-1:0] win_oh;
   logic           owner_req;
   logic           owner_release;
   logic           force_handoff;
   logic           rearb;

   // While busy the owner index is the round-robin pointer for this edge, so
   // a release arbitrates as if last had already been updated to the owner.
   assign arb_last = (state_q == ARB_BUSY) ? idx_q : last_q;

   // Only requesters strictly below the pointer are preferred.
   always_comb begin
      rr_mask = '0;
      for (int i = 0; i < REQ; i++) begin
         rr_mask[i] = (i < int'(arb_last));
      end
   end

   assign req_masked = req & rr_mask;

   pri_enc #(
      .IN  (REQ),
      .ACT (1'b1)
   ) u_enc_masked (
      .in_i    (req_masked),
      .idx_o   (m_idx),
      .valid_o (m_valid)
   );

   pri_enc #(
      .IN  (REQ),
      .ACT (1'b1)
   ) u_enc_full (
      .in_i    (req),
      .idx_o   (f_idx),
      .valid_o (f_valid)
   );

   // Wrap-around: with nothing below the pointer, fall back to plain MSB-first.
   assign win_valid = m_valid | f_valid;
   assign win_idx   = m_valid ? m_idx : f_idx;
   assign win_oh    = REQ'(onehot_from_idx(32'(win_idx)));

   assign owner_req     = |(req & grant_q);
   assign owner_release = (state_q == ARB_BUSY) && !owner_req;

`ifdef RR_ARB_BURST_LIMIT_EN
   localparam int CW = $clog2(MAX_BURST + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          preempt_q, preempt_d;
   logic          burst_done;
   logic          others_req;

   // cnt_q counts completed hold cycles after the first, so the owner is on
   // its MAX_BURST-th cycle when cnt_q reaches MAX_BURST-1.
   assign burst_done    = (cnt_q >= CW'(MAX_BURST - 1));
   assign others_req    = |(req & ~grant_q);
   assign force_handoff = (state_q == ARB_BUSY) && owner_req && burst_done && others_req;
   assign preempt       = preempt_q;
`else
   logic burst_unused;

   assign burst_unused  = (MAX_BURST > 0);
   assign force_handoff = 1'b0;
   assign preempt       = 1'b0;
`endif

   assign rearb = (state_q == ARB_IDLE) || owner_release || force_handoff;

   // ------------------------------------------------------------ next state
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      last_d  = last_q;
`ifdef RR_ARB_BURST_LIMIT_EN
      preempt_d = 1'b0;
      cnt_d     = cnt_q;
      if ((state_q == ARB_BUSY) && (cnt_q != CW'(MAX_BURST))) begin
         cnt_d = cnt_q + 1'b1;
      end
`endif
      if (rearb) begin
         if (win_valid) begin
            state_d = ARB_BUSY;
            grant_d = win_oh;
            idx_d   = win_idx;
            valid_d = 1'b1;
            last_d  = win_idx;
`ifdef RR_ARB_BURST_LIMIT_EN
            cnt_d     = '0;
            preempt_d = force_handoff;
`endif
         end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            last_d  = arb_last;
         end
      end
   end

   // ------------------------------------------------------------- registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= '0;
`ifdef RR_ARB_BURST_LIMIT_EN
         cnt_q     <= '0;
         preempt_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         last_q  <= last_d;
`ifdef RR_ARB_BURST_LIMIT_EN
         cnt_q     <= cnt_d;
         preempt_q <= preempt_d;
`endif
      end
   end

   assign grant       = grant_q;
   assign grant_valid = valid_q;
   assign grant_idx   = idx_q;
   assign dbg_state_o = state_q;

endmodule : rr_lock_arbiter

// File: doc/rr_lock_arbiter.md
# rr_lock_arbiter

Registered round-robin arbiter with grant locking that shares one single-owner resource (bus port, table write port, shared FU) among `REQ` requesters. Each requester holds `req` for the whole time it wants ownership. The arbiter grants exactly one requester at a time and holds the grant until the owner drops `req`, then hands off to the next requester in round-robin order. Selection is done by the codebase priority encoder (MSB-first) on masked and unmasked request vectors.

## Interface
Parameters:
- `REQ`, 8, number of requesters (≥2)
- `MAX_BURST`, 16, grant-hold limit in cycles (used only with `RR_ARB_BURST_LIMIT_EN`; ≥1)
- `IDX`, `$clog2(REQ)`, index width (constant, not overridden)

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous active-high reset
- `req` in REQ: request/hold, one bit per requester
- `grant` out REQ: one-hot grant, registered
- `grant_valid` out 1: `|grant`, registered
- `grant_idx` out IDX: index of the owner (0 when idle), registered
- `preempt` out 1: one-cycle pulse on a forced hand-off (burst limit)

## Operation
- States: IDLE (no owner), BUSY (owner k = `grant_idx`).
- Round-robin order is descending and starts below the last owner `last`:
  - Candidates are `last-1` down to 0, then `REQ-1` down to `last`.
  - Implementation: masked vector `req & ((1<<last)-1)`. Use its MSB-first encode if nonzero, else the MSB-first encode of `req`.
- IDLE: if `req != 0`, grant the winner and go to BUSY. Otherwise stay.
- BUSY, owner's `req[k]` = 1: keep the grant, with no re-arbitration.
- BUSY, owner's `req[k]` = 0: set `last` ← k and arbitrate on the same edge with the new mask.
  - The owner's bit is excluded because it is low.
  - Winner found: zero-bubble hand-off, stay in BUSY.
  - No winner: go to IDLE.
- A grant is only ever issued to a bit sampled high. A requester that drops `req` before being granted is simply withdrawn.
- `last` updates on every grant. Reset value of `last` is 0, so the first arbitration is plain MSB-first.
- Reset mid-grant: all outputs clear immediately (asynchronous). The owner loses its grant with no hand-off.
- Invariant: `grant` is one-hot or zero, and `grant[grant_idx]` = `grant_valid`.

## Timing
- `req` sampled at edge n drives `grant`/`grant_idx`/`grant_valid` from cycle n+1. Latency is 1 cycle, with no combinational path from `req` to the outputs.
- Hand-off: owner drops `req` in cycle n → new owner is visible in cycle n+1, or `grant_valid` = 0 if none.
- The owner must hold `req` until it finishes. The resource is owned exactly during cycles with `grant[k]` = 1.
- Reset values: `grant` = 0, `grant_valid` = 0, `grant_idx` = 0, `preempt` = 0, `last` = 0, state IDLE, burst counter 0.

## Configuration
- `RR_ARB_BURST_LIMIT_EN` defined:
  - An `$clog2(MAX_BURST+1)`-bit counter clears on each new grant and increments each BUSY cycle, saturating at `MAX_BURST`.
  - At saturation, if any other `req` bit is high, the arbiter forces a hand-off on that edge, as if the owner had released, with `last` ← k.
  - `preempt` pulses 1 in the first cycle of the new grant.
  - With no other requester, the owner keeps the grant and the counter holds at saturation.
  - A preempted owner still holding `req` competes normally and has lowest priority.
- Not defined: no counter, `preempt` tied 0, and grants are held indefinitely.

## Structure
- Package `arb_pkg`: state enum (`ARB_IDLE`, `ARB_BUSY`) and a `onehot_from_idx` function.
- Sub-module: two `pri_enc` instances (`IN=REQ`, `ACT` high), one for the masked vector and one for the unmasked vector. Their `valid` outputs select between them.

## Test plan
- Reset, then `req`=8'b0010_0100 → next cycle `grant`=8'b0010_0000, `grant_idx`=5, `grant_valid`=1.
- Owner 5 holds `req` for 10 cycles while `req[2]` and `req[7]` are high → grant stays on 5. Owner drops → next cycle `grant_idx`=2, not 7.
- All 8 `req` high, each owner releases after 1 cycle and re-asserts → grant order 7,6,5,4,3,2,1,0,7 with no idle cycle.
- Single requester 3 drops `req` → next cycle `grant_valid`=0, `grant`=0, `grant_idx`=0. Re-assert → grant 3 after 1 cycle.
- Assert `reset` asynchronously mid-grant (owner 4) → outputs 0 before the next edge. After release, `req`=8'h11 → grant 4.
- With `RR_ARB_BURST_LIMIT_EN`, `MAX_BURST`=4, `req[6]` and `req[1]` held high → grant 6 for 4 cycles, then 1 with `preempt`=1 for one cycle. Alone, owner 6 keeps the grant past 4 cycles.
